// File: rtl/ifu.sv
// ============================================================================
// ifu : instruction fetch unit, one outstanding read, valid/ready to decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module ifu #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h8000_0000)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [PC_WIDTH-1:0] mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [31:0]         mem_rsp_data,
    input  logic                mem_rsp_err,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [PC_WIDTH-1:0] inst_pc,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt,
    output logic                fetch_err,
    output logic [31:0]         inst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [31:0]           inst_q;
    logic [PC_WIDTH-1:0]   inst_pc_q;
    logic                  fetch_err_q;
    logic [31:0]           inst_cnt_q;
    logic                  redir_pend_q;
    logic [PC_WIDTH-1:0]   redir_pc_q;
    logic                  halt_pend_q;

    logic [PC_WIDTH-1:0]   redir_tgt_d;
    logic                  halt_any_d;
    logic                  redir_any_d;

    assign redir_tgt_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign halt_any_d  = halt_pend_q | halt;
    assign redir_any_d = redir_pend_q | redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fetch_err_q  <= 1'b0;
            inst_cnt_q   <= '0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            halt_pend_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= halt ? S_HALT : S_REQ;
                S_REQ: begin
                    // Request stays stable; control-flow events wait for the response.
                    if (redirect_valid) begin
                        redir_pend_q <= 1'b1;
                        redir_pc_q   <= redir_tgt_d;
                    end
                    if (halt)
                        halt_pend_q <= 1'b1;
                    if (mem_req_ready)
                        state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (mem_rsp_err) begin
                            state_q     <= S_HALT;
                            fetch_err_q <= 1'b1;
                        end else if (halt_any_d) begin
                            state_q <= S_HALT;
                        end else if (redir_any_d) begin
                            pc_q         <= redirect_valid ? redir_tgt_d : redir_pc_q;
                            redir_pend_q <= 1'b0;
                            state_q      <= S_REQ;
                        end else begin
                            inst_q    <= mem_rsp_data;
                            inst_pc_q <= pc_q;
                            state_q   <= S_HOLD;
                        end
                    end else begin
                        if (redirect_valid) begin
                            redir_pend_q <= 1'b1;
                            redir_pc_q   <= redir_tgt_d;
                        end
                        if (halt)
                            halt_pend_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Redirect beats a simultaneous accept: the held word is squashed.
                    if (halt) begin
                        state_q <= S_HALT;
                    end else if (redirect_valid) begin
                        pc_q    <= redir_tgt_d;
                        state_q <= S_REQ;
                    end else if (inst_ready) begin
                        pc_q       <= pc_q + PC_WIDTH'(4);
                        inst_cnt_q <= inst_cnt_q + 32'd1;
                        state_q    <= S_REQ;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = (state_q == S_HALT) ? '0 : pc_q;
    assign inst_valid    = (state_q == S_HOLD);
    assign inst          = (state_q == S_HALT) ? '0 : inst_q;
    assign inst_pc       = (state_q == S_HALT) ? '0 : inst_pc_q;
    assign fetch_err     = fetch_err_q;
    assign inst_cnt      = inst_cnt_q;

endmodule

`default_nettype wire
